fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the memory module.
- Generates `pc` for the RAM1 instruction port, tracks the two-clock memory access cycle, and captures the returned instruction into the IF/ID register.
- Handles three events: memory conflicts (data access owns RAM1, so the fetch is replayed), UART waits (`noStop` low, so everything freezes), and branch redirects / ID-stage stalls from the hazard logic.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory-side handshake, hazard controls and IF/ID outputs.
// master: the fetch unit; slave: the memory module / hazard logic side.
interface fetch_unit_if;
  localparam int unsigned W = 16;

  logic         noStop;
  logic         MemConflict;
  logic [W-1:0] Instruct;
  logic         branch_taken;
  logic [W-1:0] branch_target;
  logic         stall_id;
  logic [W-1:0] pc;
  logic [W-1:0] if_id_instr;
  logic [W-1:0] if_id_pc;
  logic         if_id_valid;
  logic         fetch_phase;

  modport master (
    input  noStop, MemConflict, Instruct, branch_taken, branch_target, stall_id,
    output pc, if_id_instr, if_id_pc, if_id_valid, fetch_phase
  );

  modport slave (
    output noStop, MemConflict, Instruct, branch_taken, branch_target, stall_id,
    input  pc, if_id_instr, if_id_pc, if_id_valid, fetch_phase
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives pc for RAM1, tracks the two-clock access
// (address phase / commit phase) and captures the fetched word into IF/ID.
// Optional macro FETCH_SKID_EN adds a 1-entry skid buffer so a fetch that
// completes during an ID stall is kept instead of being refetched.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int unsigned W = 16;

  typedef enum logic {PH_ADDR = 1'b0, PH_COMMIT = 1'b1} phase_t;

  phase_t       phase_q, phase_n;
  logic [W-1:0] pc_q, pc_n;
  logic [W-1:0] instr_q, instr_n;
  logic [W-1:0] ifpc_q, ifpc_n;
  logic         valid_q, valid_n;
  logic [W-1:0] pc_inc;

`ifdef FETCH_SKID_EN
  logic [W-1:0] skid_instr, skid_instr_n;
  logic [W-1:0] skid_pc, skid_pc_n;
  logic         skid_valid, skid_valid_n;
`endif

  assign pc_inc = W'(pc_q + W'(1));

  // Phase register; frozen while the memory module holds noStop low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_q <= PH_ADDR;
    else if (bus.noStop) phase_q <= phase_n;
  end

  // Next phase and next IF/ID / pc values; only the commit edge updates data.
  always_comb begin
    phase_n = (phase_q == PH_ADDR) ? PH_COMMIT : PH_ADDR;
    pc_n    = pc_q;
    instr_n = instr_q;
    ifpc_n  = ifpc_q;
    valid_n = valid_q;
`ifdef FETCH_SKID_EN
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    skid_valid_n = skid_valid;
`endif
    if (phase_q == PH_COMMIT) begin
      if (bus.branch_taken) begin
        pc_n    = bus.branch_target;
        instr_n = NOP_WORD;
        valid_n = 1'b0;
`ifdef FETCH_SKID_EN
        skid_valid_n = 1'b0;
`endif
      end else if (bus.stall_id) begin
`ifdef FETCH_SKID_EN
        // Park the completed fetch so the stall does not waste it.
        if (!bus.MemConflict && !skid_valid) begin
          skid_instr_n = bus.Instruct;
          skid_pc_n    = pc_inc;
          skid_valid_n = 1'b1;
          pc_n         = pc_inc;
        end
`endif
      end
`ifdef FETCH_SKID_EN
      // Draining the skid needs no memory, so it wins over a conflict; pc is
      // held so the word at pc (fetched this cycle) is refetched next.
      else if (skid_valid) begin
        instr_n      = skid_instr;
        ifpc_n       = skid_pc;
        valid_n      = 1'b1;
        skid_valid_n = 1'b0;
      end
`endif
      else if (bus.MemConflict) begin
        instr_n = NOP_WORD;
        valid_n = 1'b0;
      end else begin
        instr_n = bus.Instruct;
        ifpc_n  = pc_inc;
        valid_n = 1'b1;
        pc_n    = pc_inc;
      end
    end
  end

  // pc and IF/ID registers; frozen while noStop is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.noStop) begin
      pc_q    <= pc_n;
      instr_q <= instr_n;
      ifpc_q  <= ifpc_n;
      valid_q <= valid_n;
    end
  end

`ifdef FETCH_SKID_EN
  // Skid buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_valid <= 1'b0;
    end else if (bus.noStop) begin
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      skid_valid <= skid_valid_n;
    end
  end
`endif

  assign bus.pc          = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ifpc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_phase = phase_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   total;
  int   passed;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(16'h0000), .NOP_WORD(16'h0800)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst               = 1'b0;
    bus.noStop        = 1'b1;
    bus.MemConflict   = 1'b0;
    bus.Instruct      = 16'h4901;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.stall_id      = 1'b0;

    // Reset state
    step(2);
    check("rst_pc",    bus.pc,                  16'h0000);
    check("rst_phase", 16'(bus.fetch_phase),    16'h0000);
    check("rst_instr", bus.if_id_instr,         16'h0800);
    check("rst_ifpc",  bus.if_id_pc,            16'h0000);
    check("rst_valid", 16'(bus.if_id_valid),    16'h0000);

    // Two normal fetches
    rst = 1'b1;
    step(4);
    check("run_pc",    bus.pc,               16'h0002);
    check("run_instr", bus.if_id_instr,      16'h4901);
    check("run_ifpc",  bus.if_id_pc,         16'h0002);
    check("run_valid", 16'(bus.if_id_valid), 16'h0001);
    check("run_phase", 16'(bus.fetch_phase), 16'h0000);

    // Branch to 5; PH0 edge must not act on it
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0005;
    step(1);
    check("br_ph0_pc", bus.pc,               16'h0002);
    check("br_ph0_ph", 16'(bus.fetch_phase), 16'h0001);
    step(1);
    check("br5_pc",    bus.pc,               16'h0005);
    check("br5_valid", 16'(bus.if_id_valid), 16'h0000);
    check("br5_ifpc",  bus.if_id_pc,         16'h0002);

    // Memory conflict replay
    bus.branch_taken = 1'b0;
    bus.MemConflict  = 1'b1;
    step(2);
    check("mc_pc",    bus.pc,               16'h0005);
    check("mc_instr", bus.if_id_instr,      16'h0800);
    check("mc_valid", 16'(bus.if_id_valid), 16'h0000);
    bus.MemConflict = 1'b0;
    step(2);
    check("mc2_pc",    bus.pc,               16'h0006);
    check("mc2_ifpc",  bus.if_id_pc,         16'h0006);
    check("mc2_valid", 16'(bus.if_id_valid), 16'h0001);

    // Freeze in commit phase at pc 0x10
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0010;
    step(2);
    bus.branch_taken = 1'b0;
    bus.Instruct     = 16'h1234;
    step(1);
    bus.noStop = 1'b0;
    step(10);
    check("frz_pc",    bus.pc,               16'h0010);
    check("frz_phase", 16'(bus.fetch_phase), 16'h0001);
    check("frz_instr", bus.if_id_instr,      16'h0800);
    check("frz_ifpc",  bus.if_id_pc,         16'h0006);
    check("frz_valid", 16'(bus.if_id_valid), 16'h0000);
    bus.noStop = 1'b1;
    step(1);
    check("thaw_pc",    bus.pc,               16'h0011);
    check("thaw_instr", bus.if_id_instr,      16'h1234);
    check("thaw_ifpc",  bus.if_id_pc,         16'h0011);
    check("thaw_phase", 16'(bus.fetch_phase), 16'h0000);

    // Branch beats stall and conflict
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0040;
    bus.MemConflict   = 1'b1;
    bus.stall_id      = 1'b1;
    step(2);
    check("pri_pc",    bus.pc,               16'h0040);
    check("pri_valid", 16'(bus.if_id_valid), 16'h0000);
    check("pri_instr", bus.if_id_instr,      16'h0800);
    check("pri_ifpc",  bus.if_id_pc,         16'h0011);
    bus.MemConflict = 1'b0;
    bus.stall_id    = 1'b0;

    // pc wraps from FFFF to 0
    bus.branch_target = 16'hFFFF;
    step(2);
    bus.branch_taken = 1'b0;
    bus.Instruct     = 16'h5555;
    step(2);
    check("wrap_pc",    bus.pc,          16'h0000);
    check("wrap_ifpc",  bus.if_id_pc,    16'h0000);
    check("wrap_instr", bus.if_id_instr, 16'h5555);

    // Stall with conflict keeps IF/ID contents
    bus.stall_id    = 1'b1;
    bus.MemConflict = 1'b1;
    step(2);
    check("stmc_pc",    bus.pc,               16'h0000);
    check("stmc_instr", bus.if_id_instr,      16'h5555);
    check("stmc_valid", 16'(bus.if_id_valid), 16'h0001);
    bus.stall_id    = 1'b0;
    bus.MemConflict = 1'b0;

    // Stall at pc 8
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0008;
    step(2);
    bus.branch_taken = 1'b0;
    bus.Instruct     = 16'hABCD;
    bus.stall_id     = 1'b1;
    step(2);
`ifdef FETCH_SKID_EN
    check("st_pc", bus.pc, 16'h0009);
`else
    check("st_pc", bus.pc, 16'h0008);
`endif
    check("st_instr", bus.if_id_instr,      16'h0800);
    check("st_valid", 16'(bus.if_id_valid), 16'h0000);
    bus.stall_id = 1'b0;
    bus.Instruct = 16'h1111;
    step(2);
`ifdef FETCH_SKID_EN
    check("un_instr", bus.if_id_instr, 16'hABCD);
`else
    check("un_instr", bus.if_id_instr, 16'h1111);
`endif
    check("un_ifpc",  bus.if_id_pc,         16'h0009);
    check("un_pc",    bus.pc,               16'h0009);
    check("un_valid", 16'(bus.if_id_valid), 16'h0001);
    step(2);
    check("un2_pc",    bus.pc,          16'h000A);
    check("un2_instr", bus.if_id_instr, 16'h1111);
    check("un2_ifpc",  bus.if_id_pc,    16'h000A);

    // Asynchronous reset in the middle of an access
    step(1);
    #2 rst = 1'b0;
    #1;
    check("arst_pc",    bus.pc,               16'h0000);
    check("arst_phase", 16'(bus.fetch_phase), 16'h0000);
    check("arst_valid", 16'(bus.if_id_valid), 16'h0000);
    check("arst_instr", bus.if_id_instr,      16'h0800);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
